// File: rtl/fpadd_rr_sched_if.sv
// Request/adder/response bundle between client engines, the round-robin
// scheduler and the shared FP32 adder.
interface fpadd_rr_sched_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned DW = 32;

    logic [N-1:0]    req_valid;
    logic [DW*N-1:0] req_a;
    logic [DW*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   add_a;
    logic [DW-1:0]   add_b;
    logic [DW-1:0]   add_out;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic [N-1:0]    busy;

    // Environment side: clients plus the adder result.
    modport master (
        output req_valid, req_a, req_b, add_out,
        input  req_ready, add_a, add_b, resp_valid, resp_data, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, add_out,
        output req_ready, add_a, add_b, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/fpadd_rr_sched.sv
// Round-robin scheduler sharing one pipelined FP32 adder among N requesters.
// Optional per-requester grant and idle counters when FPADD_SCHED_PERF_EN is defined.
module fpadd_rr_sched #(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 2,
    parameter int unsigned IDW = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fpadd_rr_sched_if.slave        bus
`ifdef FPADD_SCHED_PERF_EN
    ,
    output logic [16*N-1:0]        grant_cnt,
    output logic [15:0]            idle_cnt
`endif
);
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    if (IDW != $clog2(N)) begin : g_bad_idw
        $error("fpadd_rr_sched: IDW must equal clog2(N)");
    end

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]   busy_q, busy_d;
    logic [LAT:0]   tag_vld_q, tag_vld_d;
    logic [IDW-1:0] tag_id_q [LAT+1];
    logic [IDW-1:0] tag_id_d [LAT+1];
    logic [DW-1:0]  add_a_q, add_a_d;
    logic [DW-1:0]  add_b_q, add_b_d;
    logic           reset_dly_q, reset_dly_d;

    logic           block_c;
    logic [N-1:0]   eligible_c;
    logic           grant_vld_c;
    logic [IDW-1:0] grant_id_c;
    logic [N-1:0]   grant_c;
    logic           resp_fire_c;
    logic [N-1:0]   resp_valid_c;

    // No grants or responses while reset is held or in the first cycle after it.
    assign block_c    = reset | reset_dly_q;
    assign eligible_c = bus.req_valid & ~busy_q;

    // Round-robin search starting at rr_ptr, wrapping N-1 -> 0.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        grant_c     = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(rr_ptr_q) + k) % N);
            if (!grant_vld_c && eligible_c[idx]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = idx;
            end
        end
        if (block_c) begin
            grant_vld_c = 1'b0;
        end
        if (grant_vld_c) begin
            grant_c[grant_id_c] = 1'b1;
        end
    end

    // Last tag stage is aligned with the adder result.
    always_comb begin
        resp_fire_c  = tag_vld_q[LAT] & ~block_c;
        resp_valid_c = '0;
        if (resp_fire_c) begin
            resp_valid_c[tag_id_q[LAT]] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        reset_dly_d = reset;
        tag_vld_d   = {tag_vld_q[LAT-1:0], grant_vld_c};
        tag_id_d[0] = grant_id_c;
        for (int unsigned s = 1; s <= LAT; s++) begin
            tag_id_d[s] = tag_id_q[s-1];
        end
        if (resp_fire_c) begin
            busy_d[tag_id_q[LAT]] = 1'b0;
        end
        if (grant_vld_c) begin
            add_a_d            = bus.req_a[DW*32'(grant_id_c) +: DW];
            add_b_d            = bus.req_b[DW*32'(grant_id_c) +: DW];
            busy_d[grant_id_c] = 1'b1;
            rr_ptr_d           = (grant_id_c == IDW'(N-1)) ? '0 : grant_id_c + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        reset_dly_q <= reset_dly_d;
        if (reset) begin
            rr_ptr_q  <= '0;
            busy_q    <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '{default: '0};
            add_a_q   <= '0;
            add_b_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
        end
    end

    assign bus.req_ready  = grant_c;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = bus.add_out;
    assign bus.busy       = busy_q;

`ifdef FPADD_SCHED_PERF_EN
    logic [CW-1:0] grant_cnt_q [N];
    logic [CW-1:0] grant_cnt_d [N];
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;

    // Saturating grant and stall counters.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (grant_c[i] && (grant_cnt_q[i] != CNT_MAX)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + CW'(1);
            end
        end
        idle_cnt_d = idle_cnt_q;
        if ((|bus.req_valid) && !grant_vld_c && (idle_cnt_q != CNT_MAX)) begin
            idle_cnt_d = idle_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q <= '{default: '0};
            idle_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_cnt_out
        assign grant_cnt[CW*g +: CW] = grant_cnt_q[g];
    end
    assign idle_cnt = idle_cnt_q;
`else
    logic unused_perf_c;
    assign unused_perf_c = ^{CNT_MAX};
`endif

endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Directed bench for fpadd_rr_sched with a table-driven two-stage adder model.
module tb_fpadd_rr_sched;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fpadd_rr_sched_if #(.N(N)) bus ();

`ifdef FPADD_SCHED_PERF_EN
    logic [16*N-1:0] grant_cnt;
    logic [15:0]     idle_cnt;
`endif

    fpadd_rr_sched #(.N(N), .LAT(2), .IDW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FPADD_SCHED_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .idle_cnt  (idle_cnt)
`endif
    );

    // Hand-computed FP32 sums for the operand pairs used below.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic [31:0] ra, rb;
    always @(posedge clk) begin
        ra          <= bus.add_a;
        rb          <= bus.add_b;
        bus.add_out <= fp_model(ra, rb);
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    // Leaves the caller at the negedge of the first cycle after a reset edge.
    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready_held got %h want 0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL rst_resp got %h want 0", bus.resp_valid); end
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL rst_busy got %h want 0", bus.busy); end
        checks++; if (bus.add_a !== 32'h0) begin errors++; $display("FAIL rst_add_a got %h want 0", bus.add_a); end
        checks++; if (bus.add_b !== 32'h0) begin errors++; $display("FAIL rst_add_b got %h want 0", bus.add_b); end
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready_after got %h want 0", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL rst_busy_idle got %h want 0", bus.busy); end
    endtask

    task automatic test_single_op();
        set_req(0, 32'h3F800000, 32'h40000000);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %h want 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++; if (bus.add_a !== 32'h3F800000) begin errors++; $display("FAIL single_add_a got %h want 3f800000", bus.add_a); end
        checks++; if (bus.add_b !== 32'h40000000) begin errors++; $display("FAIL single_add_b got %h want 40000000", bus.add_b); end
        checks++; if (bus.busy !== 4'b0001) begin errors++; $display("FAIL single_busy_t1 got %h want 1", bus.busy); end
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 4'b0001) begin errors++; $display("FAIL single_busy_t2 got %h want 1", bus.busy); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL single_resp_early got %h want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp got %h want 1", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h40400000) begin errors++; $display("FAIL single_data got %h want 40400000", bus.resp_data); end
        checks++; if (bus.busy !== 4'b0001) begin errors++; $display("FAIL single_busy_t3 got %h want 1", bus.busy); end
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL single_busy_t4 got %h want 0", bus.busy); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL single_resp_late got %h want 0", bus.resp_valid); end
    endtask

    task automatic test_all_four();
        logic [3:0]  exp_rdy [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        logic [3:0]  exp_rsp [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        logic [31:0] exp_dat [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h40400000, 32'h40800000,
                                     32'h00000000, 32'h40800000, 32'h40400000};
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000);
        set_req(1, 32'h40000000, 32'h40000000);
        set_req(2, 32'h3F800000, 32'hBF800000);
        set_req(3, 32'h40400000, 32'h3F800000);
        bus.req_valid = '1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (bus.req_ready !== exp_rdy[c]) begin errors++; $display("FAIL all4_ready c%0d got %h want %h", c, bus.req_ready, exp_rdy[c]); end
            checks++; if (bus.resp_valid !== exp_rsp[c]) begin errors++; $display("FAIL all4_resp c%0d got %h want %h", c, bus.resp_valid, exp_rsp[c]); end
            if (exp_rsp[c] != 4'h0) begin
                checks++; if (bus.resp_data !== exp_dat[c]) begin errors++; $display("FAIL all4_data c%0d got %h want %h", c, bus.resp_data, exp_dat[c]); end
            end
        end
        bus.req_valid = '0;
        wait_cycles(5);
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        int cnt0 = 0;
        int cnt2 = 0;
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000);
        set_req(2, 32'h3F800000, 32'hBF800000);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL fair_setup got %h want 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        wait_cycles(3);
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp = ((k % 4) == 0) ? 4'b0100 : (((k % 4) == 1) ? 4'b0001 : 4'b0000);
            if (bus.req_ready === 4'b0001) cnt0++;
            if (bus.req_ready === 4'b0100) cnt2++;
            checks++; if (bus.req_ready !== exp) begin errors++; $display("FAIL fair_ready k%0d got %h want %h", k, bus.req_ready, exp); end
        end
        checks++; if (cnt0 != 25) begin errors++; $display("FAIL fair_cnt0 got %0d want 25", cnt0); end
        checks++; if (cnt2 != 25) begin errors++; $display("FAIL fair_cnt2 got %0d want 25", cnt2); end
        @(negedge clk);
        bus.req_valid = '0;
        wait_cycles(5);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 32'h40000000, 32'h40000000);
        set_req(1, 32'h3F800000, 32'hBF800000);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready0 got %h want 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready1 got %h want 2", bus.req_ready); end
        checks++; if (bus.add_a !== 32'h40000000) begin errors++; $display("FAIL b2b_add_a0 got %h want 40000000", bus.add_a); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++; if (bus.add_a !== 32'h3F800000) begin errors++; $display("FAIL b2b_add_a1 got %h want 3f800000", bus.add_a); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL b2b_resp0 got %h want 1", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h40800000) begin errors++; $display("FAIL b2b_data0 got %h want 40800000", bus.resp_data); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL b2b_resp1 got %h want 2", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h00000000) begin errors++; $display("FAIL b2b_data1 got %h want 0", bus.resp_data); end
        wait_cycles(3);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant got %h want 1", bus.req_ready); end
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL mid_busy got %h want 0", bus.busy); end
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL mid_ready got %h want 0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL mid_resp_t2 got %h want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL mid_resp_t3 got %h want 0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %h want 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL mid_resp_t4 got %h want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL mid_resp_t5 got %h want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL mid_resp_new got %h want 1", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h40400000) begin errors++; $display("FAIL mid_data_new got %h want 40400000", bus.resp_data); end
        wait_cycles(3);
    endtask

`ifdef FPADD_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        set_req(3, 32'h3F800000, 32'h40000000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 4'b1000;
            @(negedge clk);
            bus.req_valid = '0;
            wait_cycles(2);
        end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        wait_cycles(3);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (grant_cnt[63:48] !== 16'd5) begin errors++; $display("FAIL perf_grant3 got %0d want 5", grant_cnt[63:48]); end
        checks++; if (grant_cnt[47:0] !== 48'd0) begin errors++; $display("FAIL perf_grant_oth got %h want 0", grant_cnt[47:0]); end
        checks++; if (idle_cnt !== 16'd2) begin errors++; $display("FAIL perf_idle got %0d want 2", idle_cnt); end
        do_reset();
        #1;
        checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL perf_grant_rst got %h want 0", grant_cnt); end
        checks++; if (idle_cnt !== 16'd0) begin errors++; $display("FAIL perf_idle_rst got %0d want 0", idle_cnt); end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_single_op();
        test_all_four();
        test_fairness();
        test_back_to_back();
        test_reset_midflight();
`ifdef FPADD_SCHED_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
